// File: rtl/frog_pkg.sv
// Shared Frog definitions: memory geometry, the loader state encoding and ALU opcodes.
// Used by the CPU, its instruction memory and the program loader.
package frog_pkg;

    localparam int         FROG_ADDR_W   = 8;
    localparam int         FROG_DATA_W   = 16;
    localparam logic [7:0] FROG_HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN,
        LD_HI,
        LD_LO,
        LD_CSUM
    } loader_state_e;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SHL  = 4'h5;
    localparam logic [3:0] ALU_SHR  = 4'h6;
    localparam logic [3:0] ALU_PASS = 4'h7;

endpackage

// File: rtl/frog_prog_loader.sv
// Framed byte-stream loader for the Frog instruction memory; holds the CPU in reset while loading.
// Define FROG_LOADER_CSUM_EN to carry and check a trailing XOR checksum byte per frame.
module frog_prog_loader
    import frog_pkg::*;
#(
    parameter int         ADDR_W   = FROG_ADDR_W,
    parameter int         DATA_W   = FROG_DATA_W,
    parameter logic [7:0] HDR_BYTE = FROG_HDR_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        acc_q, acc_d;
    logic              in_ready_q;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              xfer;

    assign xfer = in_valid & in_ready_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hi_d         = hi_q;
        acc_d        = acc_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;
        word_count_d = word_count_q;
        if (xfer) begin
            case (state_q)
                LD_IDLE: begin
                    if (in_byte == HDR_BYTE) begin
                        cpu_hold_d   = 1'b1;
                        load_done_d  = 1'b0;
                        load_err_d   = 1'b0;
                        word_count_d = '0;
                        acc_d        = '0;
                        state_d      = LD_LEN;
                    end
                end
                LD_LEN: begin
                    // A length byte of zero encodes a full 256-word frame.
                    len_d   = (in_byte == 8'h00) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(in_byte);
                    state_d = LD_HI;
                end
                LD_HI: begin
                    hi_d    = in_byte;
                    acc_d   = acc_q ^ in_byte;
                    state_d = LD_LO;
                end
                LD_LO: begin
                    acc_d        = acc_q ^ in_byte;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = word_count_q[ADDR_W-1:0];
                    mem_wdata_d  = {hi_q, in_byte};
                    word_count_d = word_count_q + 1'b1;
                    len_d        = len_q - 1'b1;
                    if (len_q == (ADDR_W+1)'(1)) begin
`ifdef FROG_LOADER_CSUM_EN
                        state_d     = LD_CSUM;
`else
                        state_d     = LD_IDLE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
`endif
                    end else begin
                        state_d = LD_HI;
                    end
                end
`ifdef FROG_LOADER_CSUM_EN
                LD_CSUM: begin
                    // A bad frame keeps the CPU held until a good frame or reset.
                    if (in_byte == acc_q) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        load_err_d  = 1'b1;
                    end
                    state_d = LD_IDLE;
                end
`endif
                default: state_d = LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LD_IDLE;
            len_q        <= '0;
            hi_q         <= '0;
            acc_q        <= '0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            acc_q        <= acc_d;
            in_ready_q   <= 1'b1;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            word_count_q <= word_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_frog_prog_loader.sv
// Directed bench for frog_prog_loader; builds frames with or without the checksum byte
// depending on FROG_LOADER_CSUM_EN, matching the RTL build.
module tb_frog_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [8:0]  word_count;

    int checks = 0;
    int failures = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  wa[$];
    logic [15:0] wd[$];
    logic [8:0]  wc[$];
    logic [7:0]  ea[$];
    logic [15:0] ed[$];

    frog_prog_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(word_count);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout got in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic send_q(input int maxgap);
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front(), (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete(); ea.delete(); ed.delete();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready, mem_we, cpu_hold, load_done, load_err} !== 5'b0 || word_count !== 9'd0 ||
            mem_addr !== 8'd0 || mem_wdata !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b we=%b hold=%b done=%b err=%b wc=%0d addr=%h data=%h want all 0",
                     in_ready, mem_we, cpu_hold, load_done, load_err, word_count, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_clock got %b want 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_release got %b want 1", in_ready);
        end
    endtask

    task automatic test_good_frame();
        clear_logs();
        send_byte(8'hA5, 0);
        #1;
        checks++;
        if (cpu_hold !== 1'b1 || load_done !== 1'b0 || word_count !== 9'd0) begin
            failures++;
            $display("FAIL good_after_hdr got hold=%b done=%b wc=%0d want 1 0 0", cpu_hold, load_done, word_count);
        end
        tx_q = '{8'h02, 8'h40, 8'h01, 8'h00, 8'h05};
`ifdef FROG_LOADER_CSUM_EN
        tx_q.push_back(8'h44);
`endif
        send_q(0);
        ea = '{8'd0, 8'd1};
        ed = '{16'h4001, 16'h0005};
        checks++;
        if (wa.size() != 2) begin
            failures++;
            $display("FAIL good_wr_count got %0d want 2", wa.size());
        end
        for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
            checks++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i] || wc[i] !== 9'(i + 1)) begin
                failures++;
                $display("FAIL good_write%0d got addr=%h data=%h wc=%0d want addr=%h data=%h wc=%0d",
                         i, wa[i], wd[i], wc[i], ea[i], ed[i], i + 1);
            end
        end
        checks++;
        if (load_done !== 1'b1 || load_err !== 1'b0 || cpu_hold !== 1'b0 || word_count !== 9'd2) begin
            failures++;
            $display("FAIL good_flags got done=%b err=%b hold=%b wc=%0d want 1 0 0 2", load_done, load_err, cpu_hold, word_count);
        end
    endtask

    task automatic test_junk_then_frame();
        clear_logs();
        tx_q = '{8'h00, 8'hFF, 8'h13};
        send_q(0);
        checks++;
        if (wa.size() != 0 || cpu_hold !== 1'b0 || load_done !== 1'b1 || word_count !== 9'd2) begin
            failures++;
            $display("FAIL junk_ignored got writes=%0d hold=%b done=%b wc=%0d want 0 0 1 2", wa.size(), cpu_hold, load_done, word_count);
        end
        tx_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef FROG_LOADER_CSUM_EN
        tx_q.push_back(8'h40);
`endif
        send_q(0);
        ea = '{8'd0, 8'd1};
        ed = '{16'h1234, 16'hABCD};
        checks++;
        if (wa.size() != 2) begin
            failures++;
            $display("FAIL junk_wr_count got %0d want 2", wa.size());
        end
        for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
            checks++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                failures++;
                $display("FAIL junk_write%0d got addr=%h data=%h want addr=%h data=%h", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 9'd2) begin
            failures++;
            $display("FAIL junk_flags got done=%b hold=%b wc=%0d want 1 0 2", load_done, cpu_hold, word_count);
        end
    endtask

    task automatic test_gaps();
        clear_logs();
        tx_q = '{8'hA5, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
`ifdef FROG_LOADER_CSUM_EN
        tx_q.push_back(8'h21);
`endif
        send_q(3);
        ea = '{8'd0, 8'd1, 8'd2};
        ed = '{16'hDEAD, 16'hBEEF, 16'h0102};
        checks++;
        if (wa.size() != 3) begin
            failures++;
            $display("FAIL gaps_wr_count got %0d want 3", wa.size());
        end
        for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
            checks++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i] || wc[i] !== 9'(i + 1)) begin
                failures++;
                $display("FAIL gaps_write%0d got addr=%h data=%h wc=%0d want addr=%h data=%h wc=%0d",
                         i, wa[i], wd[i], wc[i], ea[i], ed[i], i + 1);
            end
        end
        checks++;
        if (load_done !== 1'b1 || load_err !== 1'b0 || cpu_hold !== 1'b0 || word_count !== 9'd3) begin
            failures++;
            $display("FAIL gaps_flags got done=%b err=%b hold=%b wc=%0d want 1 0 0 3", load_done, load_err, cpu_hold, word_count);
        end
    endtask

    task automatic test_full_256();
        int bad;
        clear_logs();
        tx_q = '{8'hA5, 8'h00};
        for (int i = 0; i < 512; i++) tx_q.push_back(8'(i));
`ifdef FROG_LOADER_CSUM_EN
        tx_q.push_back(8'h00);
`endif
        send_q(0);
        checks++;
        if (wa.size() != 256) begin
            failures++;
            $display("FAIL full_wr_count got %0d want 256", wa.size());
        end
        bad = 0;
        for (int i = 0; i < wa.size() && i < 256; i++) begin
            checks++;
            if (wa[i] !== 8'(i) || wd[i] !== {8'(2 * i), 8'(2 * i + 1)}) begin
                failures++;
                bad++;
                if (bad < 5)
                    $display("FAIL full_write%0d got addr=%h data=%h want addr=%h data=%h",
                             i, wa[i], wd[i], 8'(i), {8'(2 * i), 8'(2 * i + 1)});
            end
        end
        checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 9'd256) begin
            failures++;
            $display("FAIL full_flags got done=%b hold=%b wc=%0d want 1 0 256", load_done, cpu_hold, word_count);
        end
    endtask

    task automatic test_bad_csum();
        clear_logs();
        tx_q = '{8'hA5, 8'h02, 8'h40, 8'h01, 8'h00, 8'h05};
`ifdef FROG_LOADER_CSUM_EN
        tx_q.push_back(8'h45);
`endif
        send_q(0);
        checks++;
        if (wa.size() != 2 || wd.size() != 2 || wd[0] !== 16'h4001 || wd[1] !== 16'h0005) begin
            failures++;
            $display("FAIL badcsum_writes got count=%0d want 2 writes 4001 0005", wa.size());
        end
        checks++;
`ifdef FROG_LOADER_CSUM_EN
        if (load_err !== 1'b1 || load_done !== 1'b0 || cpu_hold !== 1'b1 || word_count !== 9'd2) begin
            failures++;
            $display("FAIL badcsum_flags got err=%b done=%b hold=%b wc=%0d want 1 0 1 2", load_err, load_done, cpu_hold, word_count);
        end
`else
        if (load_err !== 1'b0 || load_done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 9'd2) begin
            failures++;
            $display("FAIL nocsum_flags got err=%b done=%b hold=%b wc=%0d want 0 1 0 2", load_err, load_done, cpu_hold, word_count);
        end
`endif
    endtask

    task automatic test_rst_mid_frame();
        clear_logs();
        tx_q = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56};
        send_q(0);
        checks++;
        if (wa.size() != 1 || wa[0] !== 8'd0 || wd[0] !== 16'h1234 || word_count !== 9'd1 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_writes got count=%0d wc=%0d hold=%b want 1 write 0:1234 wc=1 hold=1",
                     wa.size(), word_count, cpu_hold);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, mem_we, cpu_hold, load_done, load_err} !== 5'b0 || word_count !== 9'd0 ||
            mem_addr !== 8'd0 || mem_wdata !== 16'd0) begin
            failures++;
            $display("FAIL rst_async_outputs got rdy=%b hold=%b done=%b err=%b wc=%0d want all 0",
                     in_ready, cpu_hold, load_done, load_err, word_count);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        tx_q = '{8'hA5, 8'h01, 8'h77, 8'h88};
`ifdef FROG_LOADER_CSUM_EN
        tx_q.push_back(8'hFF);
`endif
        send_q(0);
        checks++;
        if (wa.size() != 1 || wa[0] !== 8'd0 || wd[0] !== 16'h7788) begin
            failures++;
            $display("FAIL rst_fresh_write got count=%0d want 1 write 0:7788", wa.size());
        end
        checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 9'd1) begin
            failures++;
            $display("FAIL rst_fresh_flags got done=%b hold=%b wc=%0d want 1 0 1", load_done, cpu_hold, word_count);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_junk_then_frame();
        test_gaps();
        test_full_256();
        test_bad_csum();
        test_rst_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
